inst_fetch_reg: RTL

//  Instruction register with memory-fetch handshake for the multicycle MIPS datapath.
//  - Control unit pulses fetch_start in the IF state; block issues one word read at pc.
//  - Block latches the returned word and holds it until the next fetch.
//  - Decoded fields are driven straight to the register file, control unit and

---
 rtl/inst_fetch_reg.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch_reg.sv
// Instruction register with a one-word memory-fetch handshake for the multicycle MIPS datapath.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module inst_fetch_reg #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000,
    parameter int          TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        flush,
    input  logic [31:0] pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        ir_valid,
    output logic        align_err,
    output logic        fetch_err,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm16,
    output logic [25:0] target26
);

    // Handshake: mem_req rises on the edge after an accepted fetch_start and stays
    // high, with mem_addr stable, until the first cycle where mem_ready is sampled high.
    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_req_q, mem_req_d;
    logic        ir_valid_q, ir_valid_d;
    logic        align_err_q, align_err_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fetch_err_q, fetch_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        ir_valid_d  = ir_valid_q;
        align_err_d = align_err_q;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        fetch_err_d = fetch_err_q;
`endif
        if (flush) begin
            state_d    = S_IDLE;
            mem_req_d  = 1'b0;
            ir_valid_d = 1'b0;
            instr_d    = RESET_INSTR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_start) begin
                        ir_valid_d = 1'b0;
                        if (pc[1:0] == 2'b00) begin
                            mem_addr_d  = pc;
                            mem_req_d   = 1'b1;
                            align_err_d = 1'b0;
                            state_d     = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                            fetch_err_d = 1'b0;
                            wait_cnt_d  = '0;
`endif
                        end else begin
                            align_err_d = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        instr_d    = mem_rdata;
                        mem_req_d  = 1'b0;
                        ir_valid_d = 1'b1;
                        state_d    = S_IDLE;
`ifdef FETCH_TIMEOUT_EN
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        fetch_err_d = 1'b1;
                        mem_req_d   = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            instr_q     <= RESET_INSTR;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            ir_valid_q  <= 1'b0;
            align_err_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q  <= '0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            ir_valid_q  <= ir_valid_d;
            align_err_q <= align_err_d;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign busy      = (state_q == S_WAIT);
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign ir_valid  = ir_valid_q;
    assign align_err = align_err_q;
    assign instr     = instr_q;

    assign op       = instr_q[31:26];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign rd       = instr_q[15:11];
    assign shamt    = instr_q[10:6];
    assign funct    = instr_q[5:0];
    assign imm16    = instr_q[15:0];
    assign target26 = instr_q[25:0];

endmodule
